// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared sizing constants and types for the decode-stage datapath.
//   DATA_W   : register / datapath width
//   ADDR_W   : register index width
//   NUM_REGS : number of architectural registers
//   ZERO_REG : index of the hard-wired zero register
//   regidx_t : register index type
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [ADDR_W-1:0] regidx_t;

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w
//   Two-read, one-write register file with a hard-wired zero register and
//   write-through bypass from the write port to both read ports.
//   clk, rst_n : clock, synchronous active-low reset (clears every entry)
//   we, wa, wd : write strobe, write index, write data
//   ra0, ra1   : read indices (combinational)
//   rd0, rd1   : read data (combinational)
module regfile_2r1w
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];

  // The whole array, including entry 0, is cleared on reset so no unknown
  // value can ever leave a read port. Entry 0 is never written afterwards,
  // and a write landing in the same cycle as reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Read priority: zero register, then the in-flight write, then storage.
  // The bypass removes the need for a write-first array.
  always_comb begin
    rd0 = regs[ra0];
    if (ra0 == '0) begin
      rd0 = '0;
    end else if (we && (wa == ra0)) begin
      rd0 = wd;
    end

    rd1 = regs[ra1];
    if (ra1 == '0) begin
      rd1 = '0;
    end else if (we && (wa == ra1)) begin
      rd1 = wd;
    end
  end

endmodule

// File: rtl/regfile_decode_port.sv
// regfile_decode_port
//   Decode-stage register file plus the ID/EX operand latch. Receives the
//   write-back port, reads rs/rt for the instruction in ID and registers the
//   operands, indices and valid bit into ID/EX under hazard-unit control.
//   clk, rst_n                          : clock, synchronous active-low reset
//   IfIdRs, IfIdRt, IfIdValid           : operand indices / valid from IF/ID
//   WriteRegEnable, ToWritereg, writeData : write-back port
//   IdStall, IdFlush                    : hold / bubble the ID/EX latch
//   IdExRsData, IdExRtData              : registered operands
//   IdExRs, IdExRt, IdExValid           : registered indices and valid
module regfile_decode_port
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] IfIdRs,
  input  logic [ADDR_W-1:0] IfIdRt,
  input  logic              IfIdValid,
  input  logic              WriteRegEnable,
  input  logic [ADDR_W-1:0] ToWritereg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              IdStall,
  input  logic              IdFlush,
  output logic [DATA_W-1:0] IdExRsData,
  output logic [DATA_W-1:0] IdExRtData,
  output logic [ADDR_W-1:0] IdExRs,
  output logic [ADDR_W-1:0] IdExRt,
  output logic              IdExValid
);

  logic [DATA_W-1:0] rsData;
  logic [DATA_W-1:0] rtData;

  regfile_2r1w #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_regfile (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (WriteRegEnable),
    .wa   (ToWritereg),
    .wd   (writeData),
    .ra0  (IfIdRs),
    .ra1  (IfIdRt),
    .rd0  (rsData),
    .rd1  (rtData)
  );

  // ID/EX latch. Flush outranks stall so a squashed instruction cannot be
  // held in EX. A stalled latch deliberately keeps stale operands even if
  // write-back updates their source register; downstream forwarding keys
  // on IdExRs/IdExRt to cover that case.
  always_ff @(posedge clk) begin
    if (!rst_n || IdFlush) begin
      IdExRsData <= '0;
      IdExRtData <= '0;
      IdExRs     <= '0;
      IdExRt     <= '0;
      IdExValid  <= 1'b0;
    end else if (!IdStall) begin
      IdExRsData <= rsData;
      IdExRtData <= rtData;
      IdExRs     <= IfIdRs;
      IdExRt     <= IfIdRt;
      IdExValid  <= IfIdValid;
    end
  end

endmodule

// File: tb/tb_regfile_decode_port.sv
// tb_regfile_decode_port
//   Scoreboard bench: stimulus computes the expected ID/EX contents from an
//   array-based reference model and queues them; an independent monitor
//   compares the DUT outputs after every rising edge.
module tb_regfile_decode_port;
  import mips_pkg::*;

  typedef struct packed {
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        valid;
  } idex_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  IfIdRs;
  logic [4:0]  IfIdRt;
  logic        IfIdValid;
  logic        WriteRegEnable;
  logic [4:0]  ToWritereg;
  logic [31:0] writeData;
  logic        IdStall;
  logic        IdFlush;
  logic [31:0] IdExRsData;
  logic [31:0] IdExRtData;
  logic [4:0]  IdExRs;
  logic [4:0]  IdExRt;
  logic        IdExValid;

  regfile_decode_port dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IfIdRs        (IfIdRs),
    .IfIdRt        (IfIdRt),
    .IfIdValid     (IfIdValid),
    .WriteRegEnable(WriteRegEnable),
    .ToWritereg    (ToWritereg),
    .writeData     (writeData),
    .IdStall       (IdStall),
    .IdFlush       (IdFlush),
    .IdExRsData    (IdExRsData),
    .IdExRtData    (IdExRtData),
    .IdExRs        (IdExRs),
    .IdExRt        (IdExRt),
    .IdExValid     (IdExValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] modelMem [NUM_REGS];
  idex_t       modelLatch;
  idex_t       expQ [$];

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] idx,
                                            input logic we, input logic [4:0] wa,
                                            input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (we && wa == idx) return wd;
    return modelMem[idx];
  endfunction

  // Drive one cycle of inputs, predict the latch after the coming edge,
  // queue that prediction, then advance the model's architectural state.
  task automatic applyStimulus(input logic rn, input logic [4:0] rs,
                               input logic [4:0] rt, input logic v,
                               input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic stall,
                               input logic flush);
    @(negedge clk);
    rst_n = rn; IfIdRs = rs; IfIdRt = rt; IfIdValid = v;
    WriteRegEnable = we; ToWritereg = wa; writeData = wd;
    IdStall = stall; IdFlush = flush;

    if (!rn || flush) begin
      modelLatch = '0;
    end else if (!stall) begin
      modelLatch.rsData = modelRead(rs, we, wa, wd);
      modelLatch.rtData = modelRead(rt, we, wa, wd);
      modelLatch.rs     = rs;
      modelLatch.rt     = rt;
      modelLatch.valid  = v;
    end
    expQ.push_back(modelLatch);

    if (!rn) begin
      for (int i = 0; i < NUM_REGS; i++) modelMem[i] = 32'd0;
    end else if (we && wa != 5'd0) begin
      modelMem[wa] = wd;
    end
  endtask

  // Monitor: the latch presents a new result after every rising edge.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      idex_t e;
      e = expQ.pop_front();
      checkOutput("IdExRsData", IdExRsData, e.rsData);
      checkOutput("IdExRtData", IdExRtData, e.rtData);
      checkOutput("IdExRs", {27'd0, IdExRs}, {27'd0, e.rs});
      checkOutput("IdExRt", {27'd0, IdExRt}, {27'd0, e.rt});
      checkOutput("IdExValid", {31'd0, IdExValid}, {31'd0, e.valid});
    end
  end

  initial begin
    rst_n = 1'b0; IfIdRs = '0; IfIdRt = '0; IfIdValid = 1'b0;
    WriteRegEnable = 1'b0; ToWritereg = '0; writeData = '0;
    IdStall = 1'b0; IdFlush = 1'b0;
    modelLatch = '0;
    for (int i = 0; i < NUM_REGS; i++) modelMem[i] = 32'd0;

    // Reset then read
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5, 31, 1, 0, 0, 0, 0, 0);
    // Write then read next cycle
    applyStimulus(1, 0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0);
    applyStimulus(1, 7, 0, 1, 0, 0, 0, 0, 0);
    // Same-cycle bypass on both ports
    applyStimulus(1, 3, 3, 1, 1, 3, 32'hFFFFFFFB, 0, 0);
    // Zero register: write, concurrent write, plain read
    applyStimulus(1, 0, 0, 0, 1, 0, 32'h1234, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 0, 32'h1234, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0);
    // Stall/flush priority, with a write to the held register during stall
    applyStimulus(1, 7, 3, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 2, 0, 1, 7, 32'hCAFEF00D, 1, 0);
    applyStimulus(1, 4, 5, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 7, 3, 1, 0, 0, 0, 1, 1);
    applyStimulus(1, 7, 3, 1, 0, 0, 0, 0, 0);
    // Reset while stalled with a write to r9 in flight
    applyStimulus(1, 9, 9, 1, 1, 9, 32'h11, 0, 0);
    applyStimulus(1, 9, 9, 1, 0, 0, 0, 1, 0);
    applyStimulus(0, 9, 9, 1, 1, 9, 32'h55, 1, 0);
    applyStimulus(1, 9, 7, 1, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom);
      applyStimulus(($urandom % 60) != 0, 5'($urandom), ($urandom % 4 == 0) ? wa : 5'($urandom),
                    1'($urandom), ($urandom % 3) != 0, wa, $urandom,
                    ($urandom % 5) == 0, ($urandom % 9) == 0);
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clk);
    #2;
    if (expQ.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d results pending, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
